// File: rtl/gate_sweep_checker_if.sv
// Pin bundle between the sweep checker and the 2-input gate under test.
// The checker drives a/b and samples y; the gate does the reverse.
interface gate_sweep_checker_if;
    logic a;
    logic b;
    logic y;

    modport master (output a, output b, input y);
    modport slave  (input a, input b, output y);
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps {a,b} = 00,01,10,11 into a 2-input gate, holds each vector HOLD_CYCLES
// cycles, then compares y against TRUTH[{a,b}] and accumulates per-vector failures.
//
//   state | meaning
//   IDLE  | a=b=0, results held, waiting for start
//   HOLD  | vector idx driven, hold_cnt counting down to 0
//   CHECK | y sampled and compared against TRUTH[idx]
//   FIN   | done pulse, pass valid, back to IDLE
module gate_sweep_checker #(
    parameter int unsigned HOLD_CYCLES = 5,
    parameter logic [3:0]  TRUTH       = 4'b1110
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    gate_sweep_checker_if.master        gate,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  err_count,
    output logic [3:0]                  fail_vec
);

    typedef enum logic [1:0] {IDLE, HOLD, CHECK, FIN} state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [2:0]  err_nxt;
    logic [3:0]  fail_nxt;
    logic        pass_nxt;
    logic        a_q, b_q, a_nxt, b_nxt;
    logic        mismatch;

    assign gate.a = a_q;
    assign gate.b = b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            hold_cnt  <= 8'd0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hold_cnt  <= hold_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
            pass      <= pass_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hold_nxt  = hold_cnt;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;
        a_nxt     = a_q;
        b_nxt     = b_q;
        mismatch  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
                if (start) begin
                    state_nxt = HOLD;
                    idx_nxt   = 2'd0;
                    hold_nxt  = HOLD_RELOAD;
                    err_nxt   = 3'd0;
                    fail_nxt  = 4'd0;
                    pass_nxt  = 1'b0;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (hold_cnt == 8'd0) begin
                    state_nxt = CHECK;
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                end
            end
            CHECK: begin
                busy     = 1'b1;
                mismatch = (gate.y != TRUTH[idx]);
                if (mismatch) begin
                    fail_nxt[idx] = 1'b1;
                    err_nxt       = err_count + 3'd1;
                end
                if (idx == 2'd3) begin
                    state_nxt = FIN;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    // Decided here so pass already reflects the last vector while in FIN.
                    pass_nxt  = (err_nxt == 3'd0);
                end else begin
                    state_nxt      = HOLD;
                    idx_nxt        = idx + 2'd1;
                    hold_nxt       = HOLD_RELOAD;
                    {a_nxt, b_nxt} = idx + 2'd1;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
